// File: rtl/dec2bin_seq_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter.
//   DIGIT_W  : bits per BCD digit (only 4 is supported)
//   BCD_MAX  : largest legal BCD digit value
//   state_e  : converter FSM states (IDLE=0, CONV=1, DONE=2)
package dec2bin_seq_pkg;

    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_mac.sv
// One multiply-accumulate step of decimal-to-binary conversion: acc*10 + digit.
// Purely combinational.
//   acc_i       : running binary accumulator (ACC_W bits)
//   digit_i     : next BCD digit, most significant first
//   acc_o       : acc_i*10 + digit_i, built as (acc<<3)+(acc<<1)+digit
//   digit_bad_o : digit_i is not a legal BCD digit (> 9)
//   ovf_o       : result has a bit set at or above OUT_W
module bcd_digit_mac
    import dec2bin_seq_pkg::*;
#(
    parameter int ACC_W       = 24,
    parameter int OUT_W       = 20,
    parameter int DIGIT_WIDTH = DIGIT_W
) (
    input  logic [ACC_W-1:0]       acc_i,
    input  logic [DIGIT_WIDTH-1:0] digit_i,
    output logic [ACC_W-1:0]       acc_o,
    output logic                   digit_bad_o,
    output logic                   ovf_o
);

    always_comb begin
        acc_o       = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);
        digit_bad_o = (digit_i > DIGIT_WIDTH'(BCD_MAX));
        // The 4 guard bits above OUT_W catch any step that leaves the result range.
        ovf_o       = |acc_o[ACC_W-1:OUT_W];
    end

endmodule

// File: rtl/dec2bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : conversion request, accepted in IDLE or DONE
//   bcd_in  : COUNT packed BCD digits, digit COUNT-1 in the MSBs
//   bin_out : converted value (all ones on error), held between done pulses
//   busy    : high while digits are being consumed
//   done    : one-cycle pulse when bin_out/err are freshly updated
//   err     : invalid digit and/or overflow seen during the conversion
// A request sampled at edge N consumes digits on edges N+1..N+COUNT; the last
// of these moves to DONE, so done is high in the cycle after edge N+COUNT.
// A start in DONE restarts immediately, giving one result per COUNT+1 cycles.
module dec2bin_seq
    import dec2bin_seq_pkg::*;
#(
    parameter int COUNT       = 6,
    parameter int DATA_WIDTH  = 20,
    parameter int DIGIT_WIDTH = DIGIT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [COUNT*DIGIT_WIDTH-1:0] bcd_in,
    output logic [DATA_WIDTH-1:0]        bin_out,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int SR_W  = COUNT * DIGIT_WIDTH;
    localparam int ACC_W = DATA_WIDTH + 4;
    localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COUNT - 1);

    state_e                 state_q, state_d;
    logic [SR_W-1:0]        shift_q, shift_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   err_acc_q, err_acc_d;
    logic [DATA_WIDTH-1:0]  bin_q, bin_d;
    logic                   err_q, err_d;

    logic [DIGIT_WIDTH-1:0] digit;
    logic [ACC_W-1:0]       mac_acc;
    logic                   mac_bad;
    logic                   mac_ovf;
    logic                   accept;
    logic                   last_digit;

    assign digit      = shift_q[SR_W-1 -: DIGIT_WIDTH];
    assign last_digit = (idx_q == '0);
    // A request is only honoured when not mid-conversion.
    assign accept     = start && (state_q != ST_CONV);

    bcd_digit_mac #(
        .ACC_W       (ACC_W),
        .OUT_W       (DATA_WIDTH),
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_mac (
        .acc_i       (acc_q),
        .digit_i     (digit),
        .acc_o       (mac_acc),
        .digit_bad_o (mac_bad),
        .ovf_o       (mac_ovf)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CONV;
            ST_CONV: if (last_digit) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_CONV : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ST_CONV);
        done = (state_q == ST_DONE);
    end

    assign bin_out = bin_q;
    assign err     = err_q;

    // ---------------- datapath next state ----------------
    always_comb begin
        shift_d   = shift_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        err_acc_d = err_acc_q;
        bin_d     = bin_q;
        err_d     = err_q;
        if (accept) begin
            shift_d   = bcd_in;
            acc_d     = '0;
            idx_d     = IDX_LAST;
            err_acc_d = 1'b0;
        end else if (state_q == ST_CONV) begin
            shift_d   = shift_q << DIGIT_WIDTH;
            acc_d     = mac_acc;
            idx_d     = idx_q - 1'b1;
            err_acc_d = err_acc_q | mac_bad | mac_ovf;
            // Results are committed on the edge that enters DONE, using the
            // final MAC step directly so no extra cycle is spent.
            if (last_digit) begin
                err_d = err_acc_d;
                bin_d = err_acc_d ? '1 : mac_acc[DATA_WIDTH-1:0];
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            err_acc_q <= 1'b0;
            bin_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            err_acc_q <= err_acc_d;
            bin_q     <= bin_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_dec2bin_seq.sv
// Bench for dec2bin_seq: directed cases plus randomized requests, compared to a
// decimal-weighting reference model. A second instance uses COUNT=7.
module tb_dec2bin_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start7;
    logic [23:0] bcd_in;
    logic [27:0] bcd7;
    logic [19:0] bin_out, bin_out7;
    logic        busy, done, err, busy7, done7, err7;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dec2bin_seq #(.COUNT(6), .DATA_WIDTH(20), .DIGIT_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .bin_out(bin_out), .busy(busy), .done(done), .err(err));

    dec2bin_seq #(.COUNT(7), .DATA_WIDTH(20), .DIGIT_WIDTH(4)) u_dut7 (
        .clk(clk), .rst(rst), .start(start7), .bcd_in(bcd7),
        .bin_out(bin_out7), .busy(busy7), .done(done7), .err(err7));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value = sum of digit*10^position; error on any non-decimal digit or a
    // value beyond 20 bits (accumulation is monotonic, so the final value
    // exceeding the range is the same as some step exceeding it).
    function automatic void model(input logic [27:0] bcd, input int cnt,
                                  output logic [19:0] bin, output logic e);
        longint v = 0;
        longint p = 1;
        bit bad = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            int d = int'(bcd[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            v += d * p;
            p *= 10;
        end
        e   = bad || (v > 64'hFFFFF);
        bin = e ? 20'hFFFFF : v[19:0];
    endfunction

    function automatic logic [23:0] to_bcd(input int n);
        logic [23:0] b;
        int x = n;
        for (int i = 0; i < 6; i++) begin
            b[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return b;
    endfunction

    // Issue one request on the chosen instance, starting at a negedge, and
    // check latency, result, single-cycle done and result hold.
    task automatic run(input bit sel7, input logic [27:0] bcd, input string tag);
        logic [19:0] eb;
        logic        ee;
        int          cnt = sel7 ? 7 : 6;
        int          lat = 0;
        bit          seen = 1'b0;
        model(bcd, cnt, eb, ee);
        if (sel7) begin start7 = 1'b1; bcd7 = bcd; end
        else      begin start  = 1'b1; bcd_in = bcd[23:0]; end
        @(posedge clk);
        #1;
        start  = 1'b0;
        start7 = 1'b0;
        // Input changes during conversion must not matter.
        bcd_in = 24'($urandom);
        bcd7   = 28'($urandom);
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            check({tag, "_busy_done_mutex"}, sel7 ? 32'(busy7 & done7) : 32'(busy & done), 0);
            if (sel7 ? done7 : done) seen = 1'b1;
        end
        check({tag, "_latency"}, lat, cnt + 1);
        check({tag, "_bin"}, sel7 ? 32'(bin_out7) : 32'(bin_out), 32'(eb));
        check({tag, "_err"}, sel7 ? 32'(err7) : 32'(err), 32'(ee));
        @(negedge clk);
        check({tag, "_done_pulse"}, sel7 ? 32'(done7) : 32'(done), 0);
        check({tag, "_bin_hold"}, sel7 ? 32'(bin_out7) : 32'(bin_out), 32'(eb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        int late_done;
        rst    = 1'b1;
        start  = 1'b0;
        start7 = 1'b0;
        bcd_in = '0;
        bcd7   = '0;
        repeat (2) @(negedge clk);
        check("rst_bin", 32'(bin_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        run(1'b0, 28'h0123456, "t1_123456");
        run(1'b0, 28'h0999999, "t2_999999");
        run(1'b0, 28'h0000000, "t2_zero");
        run(1'b0, 28'h012A456, "t3_bad_digit");
        run(1'b0, 28'h0000010, "t3_after_err");

        // Start held high: back-to-back requests every 7 cycles; the high
        // level during conversion must not spawn extra results.
        extra = 0;
        start = 1'b1;
        bcd_in = 24'h000001;
        @(posedge clk);
        #1 bcd_in = 24'h000002;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 7) begin
                check("t4_done_a", 32'(done), 1);
                check("t4_bin_a", 32'(bin_out), 1);
            end else if (c == 14) begin
                check("t4_done_b", 32'(done), 1);
                check("t4_bin_b", 32'(bin_out), 2);
                start = 1'b0;
            end else if (done) begin
                extra++;
            end
        end
        check("t4_no_extra_done", extra, 0);
        @(negedge clk);

        // Asynchronous reset in the middle of a conversion.
        start  = 1'b1;
        bcd_in = 24'h123456;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_bin", 32'(bin_out), 0);
        check("t5_rst_err", 32'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) late_done++;
        end
        check("t5_no_done_after_abort", late_done, 0);
        run(1'b0, 28'h0000042, "t5_42");

        run(1'b1, 28'h1048576, "t6_ovf");
        run(1'b1, 28'h1048575, "t6_max");

        for (int k = 0; k < 16; k++)
            run(1'b0, {4'h0, to_bcd(int'($urandom_range(0, 999999)))}, "rnd_valid");
        for (int k = 0; k < 8; k++)
            run(1'b0, {4'h0, 24'($urandom)}, "rnd_any");
        for (int k = 0; k < 6; k++)
            run(1'b1, 28'($urandom), "rnd7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
